nec_ir_tx: RTL

- NEC-protocol infrared transmitter: the sending end of the IR link that the design's `ir_rx` receiver decodes.
- Accepts an 8-bit address and 8-bit command over a valid/ready handshake, serialises a standard NEC frame, and drives a carrier-modulated LED output.
- While `hold` is asserted at the end of a frame, it emits NEC repeat codes.
- Sits in the FPGA fabric beside the other Qsys conduit peripherals. Its outputs go to an IR LED driver pin and can be looped back to `ir_rx` for self-test.

---
 rtl/nec_ir_tx.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/nec_ir_tx.sv
// -----------------------------------------------------------------------------
// nec_ir_tx
//   NEC-protocol infrared transmitter. Takes an 8-bit address and command,
//   sends the 32-bit NEC frame {~cmd, cmd, ~addr, addr} LSB first as a
//   carrier-modulated mark/space pattern. Every frame and every repeat code
//   fills a fixed 192-unit slot. While `hold` is high on the last cycle of a
//   slot, a repeat code follows in the next slot.
//
// Parameters
//   UNIT_CYCLES  : clocks per NEC unit (562.5 us)
//   CARRIER_DIV  : clocks per carrier period
//   CARRIER_HIGH : carrier high clocks per period
//                  (0 < CARRIER_HIGH < CARRIER_DIV <= UNIT_CYCLES)
//
// Ports
//   clk        in   system clock, rising edge
//   reset      in   synchronous active-high reset
//   tx_addr    in   NEC address, sampled on accept
//   tx_cmd     in   NEC command, sampled on accept
//   tx_valid   in   request to send a frame
//   tx_ready   out  high only while idle
//   hold       in   key held; sampled on the last cycle of each slot
//   busy       out  high whenever not idle
//   ir_env     out  mark envelope (1 = mark)
//   ir_tx      out  envelope AND carrier
//   state_dbg  out  current FSM state encoding
//
// Handshake: a transfer happens on any rising edge where tx_valid and
// tx_ready are both high. tx_ready is high only in IDLE, so tx_valid is
// ignored for the whole of a frame and any repeats that follow it.
// -----------------------------------------------------------------------------
module nec_ir_tx #(
  parameter int UNIT_CYCLES  = 28125,
  parameter int CARRIER_DIV  = 1316,
  parameter int CARRIER_HIGH = 439
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_addr,
  input  logic [7:0] tx_cmd,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       hold,
  output logic       busy,
  output logic       ir_env,
  output logic       ir_tx,
  output logic [3:0] state_dbg
);

  localparam int CYC_W = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
  localparam int CAR_W = (CARRIER_DIV > 1) ? $clog2(CARRIER_DIV) : 1;

  localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(UNIT_CYCLES - 1);
  localparam logic [CAR_W-1:0] CAR_LAST = CAR_W'(CARRIER_DIV - 1);
  localparam logic [CAR_W-1:0] CAR_HIGH = CAR_W'(CARRIER_HIGH);
  localparam logic [7:0]       SLOT_LAST = 8'd191;

  typedef enum logic [3:0] {
    S_IDLE       = 4'd0,
    S_LEAD_MARK  = 4'd1,
    S_LEAD_SPACE = 4'd2,
    S_BIT_MARK   = 4'd3,
    S_BIT_SPACE  = 4'd4,
    S_STOP_MARK  = 4'd5,
    S_GAP        = 4'd6,
    S_REP_MARK   = 4'd7,
    S_REP_SPACE  = 4'd8,
    S_REP_STOP   = 4'd9
  } state_t;

  state_t           state, state_next;
  logic [CYC_W-1:0] cyc_cnt, cyc_next;
  logic [3:0]       unit_cnt, unit_next;
  logic [7:0]       slot_cnt, slot_next;
  logic [4:0]       bit_idx, bit_next;
  logic [CAR_W-1:0] car_cnt, car_next;
  logic [31:0]      frame_q;
  logic             accept;
  logic             unit_end;
  logic             cur_bit;

  function automatic logic is_mark(input state_t s);
    return (s == S_LEAD_MARK) || (s == S_BIT_MARK) || (s == S_STOP_MARK) ||
           (s == S_REP_MARK)  || (s == S_REP_STOP);
  endfunction

  assign accept    = tx_valid & tx_ready;
  assign unit_end  = (cyc_cnt == CYC_LAST);
  assign cur_bit   = frame_q[bit_idx];
  assign state_dbg = state;

  // Next-state and counter logic. Every state change happens on a unit
  // boundary; GAP ends on slot position rather than on its own unit count,
  // so frames and repeats share one exit path.
  always_comb begin
    state_next = state;
    cyc_next   = cyc_cnt;
    unit_next  = unit_cnt;
    slot_next  = slot_cnt;
    bit_next   = bit_idx;
    car_next   = '0;

    if (state == S_IDLE) begin
      cyc_next  = '0;
      unit_next = '0;
      slot_next = '0;
      bit_next  = '0;
      if (accept) begin
        state_next = S_LEAD_MARK;
      end
    end else begin
      cyc_next = unit_end ? '0 : cyc_cnt + 1'b1;
      if (unit_end) begin
        slot_next = slot_cnt + 1'b1;
        unit_next = unit_cnt + 1'b1;
        case (state)
          S_LEAD_MARK: begin
            if (unit_cnt == 4'd15) begin
              state_next = S_LEAD_SPACE;
              unit_next  = '0;
            end
          end
          S_LEAD_SPACE: begin
            if (unit_cnt == 4'd7) begin
              state_next = S_BIT_MARK;
              unit_next  = '0;
            end
          end
          S_BIT_MARK: begin
            state_next = S_BIT_SPACE;
            unit_next  = '0;
          end
          S_BIT_SPACE: begin
            // A one has a three-unit space, a zero a single unit.
            if (unit_cnt == (cur_bit ? 4'd2 : 4'd0)) begin
              unit_next  = '0;
              bit_next   = bit_idx + 1'b1;
              state_next = (bit_idx == 5'd31) ? S_STOP_MARK : S_BIT_MARK;
            end
          end
          S_STOP_MARK: begin
            state_next = S_GAP;
            unit_next  = '0;
          end
          S_GAP: begin
            if (slot_cnt == SLOT_LAST) begin
              slot_next  = '0;
              unit_next  = '0;
              state_next = hold ? S_REP_MARK : S_IDLE;
            end
          end
          S_REP_MARK: begin
            if (unit_cnt == 4'd15) begin
              state_next = S_REP_SPACE;
              unit_next  = '0;
            end
          end
          S_REP_SPACE: begin
            if (unit_cnt == 4'd3) begin
              state_next = S_REP_STOP;
              unit_next  = '0;
            end
          end
          S_REP_STOP: begin
            state_next = S_GAP;
            unit_next  = '0;
          end
          default: begin
            state_next = S_IDLE;
            unit_next  = '0;
          end
        endcase
      end
    end

    // Carrier phase restarts on the first cycle of every mark so each mark
    // begins with a full high phase; it is held at zero outside marks.
    if (is_mark(state_next) && (state_next == state)) begin
      car_next = (car_cnt == CAR_LAST) ? '0 : car_cnt + 1'b1;
    end
  end

  // Outputs are registered from next-state values so they line up with the
  // state they describe, with no extra cycle of latency.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      cyc_cnt  <= '0;
      unit_cnt <= '0;
      slot_cnt <= '0;
      bit_idx  <= '0;
      car_cnt  <= '0;
      frame_q  <= '0;
      tx_ready <= 1'b1;
      busy     <= 1'b0;
      ir_env   <= 1'b0;
      ir_tx    <= 1'b0;
    end else begin
      state    <= state_next;
      cyc_cnt  <= cyc_next;
      unit_cnt <= unit_next;
      slot_cnt <= slot_next;
      bit_idx  <= bit_next;
      car_cnt  <= car_next;
      if (accept) begin
        frame_q <= {~tx_cmd, tx_cmd, ~tx_addr, tx_addr};
      end
      tx_ready <= (state_next == S_IDLE);
      busy     <= (state_next != S_IDLE);
      ir_env   <= is_mark(state_next);
      ir_tx    <= is_mark(state_next) && (car_next < CAR_HIGH);
    end
  end

endmodule
